// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
// Holds the default 800x600@60 Hz timing (40 MHz pixel clock) for both
// axes and the width of the internal position counters.
package vga_timing_pkg;

  // Wide enough for a total of up to 2048 clocks/lines per axis.
  localparam int CNT_W = 11;

  // Horizontal timing, in pixel clocks.
  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FRONT   = 40;
  localparam int DEF_H_SYNC    = 128;
  localparam int DEF_H_BACK    = 88;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  // Vertical timing, in lines.
  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FRONT   = 1;
  localparam int DEF_V_SYNC    = 4;
  localparam int DEF_V_BACK    = 23;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster: a position counter that wraps after
// VISIBLE+FRONT+SYNC+BACK counts, plus combinational decode of the
// sync window and the visible region for the current count.
// Ports:
//   clk     pixel clock
//   reset   synchronous active-high reset, counter returns to 0
//   en      count enable (1 for the horizontal axis, line wrap for vertical)
//   cnt     current position
//   wrap    high when the counter is enabled and at its last position
//   sync    sync level for the current position (POL when inside the window)
//   active  high while the position is inside the visible region
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK,
  parameter bit POL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(VISIBLE + FRONT + SYNC + BACK - 1);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(VISIBLE + FRONT + SYNC);
  localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign cnt    = cnt_reg;
  assign wrap   = en && (cnt_reg == LAST);
  assign sync   = ((cnt_reg >= SYNC_START) && (cnt_reg < SYNC_END)) ? POL : ~POL;
  assign active = (cnt_reg < VIS_END);

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator.
// Two axis counters (horizontal clocked every pixel, vertical advanced on
// each line wrap) are decoded and then registered, so all five outputs
// describe the same pixel, one clock after the counters held it.
// Totals must stay <= 2048 per axis and visible sizes <= 1024.
// Ports:
//   clk       pixel clock
//   reset     synchronous active-high reset
//   x, y      visible column/row, forced to 0 outside the visible area
//   in_frame  current pixel lies inside the visible area
//   hsync     horizontal sync, active level H_POL
//   vsync     vertical sync, active level V_POL
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit H_POL     = 1'b1,
  parameter bit V_POL     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       in_frame,
  output logic       hsync,
  output logic       vsync
);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_sync;
  logic             v_sync;
  logic             h_active;
  logic             v_active;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (H_POL)
  ) u_h_axis (
    .clk    (clk),
    .reset  (reset),
    .en     (1'b1),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .sync   (h_sync),
    .active (h_active)
  );

  // The vertical axis only moves when a line ends, so it wraps on the
  // same clock as the horizontal counter's final wrap of the frame.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (V_POL)
  ) u_v_axis (
    .clk    (clk),
    .reset  (reset),
    .en     (h_wrap),
    .cnt    (v_cnt),
    .wrap   (v_wrap),
    .sync   (v_sync),
    .active (v_active)
  );

  // Frame wrap and counter MSBs are not needed by the output stage.
  logic unused_bits;
  assign unused_bits = ^{v_wrap, h_cnt[CNT_W-1], v_cnt[CNT_W-1]};

  logic       visible;
  logic [9:0] x_reg;
  logic [9:0] y_reg;
  logic       in_frame_reg;
  logic       hsync_reg;
  logic       vsync_reg;

  assign visible = h_active && v_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg        <= '0;
      y_reg        <= '0;
      in_frame_reg <= 1'b0;
      hsync_reg    <= ~H_POL;
      vsync_reg    <= ~V_POL;
    end else begin
      x_reg        <= visible ? h_cnt[9:0] : 10'd0;
      y_reg        <= visible ? v_cnt[9:0] : 10'd0;
      in_frame_reg <= visible;
      hsync_reg    <= h_sync;
      vsync_reg    <= v_sync;
    end
  end

  assign x        = x_reg;
  assign y        = y_reg;
  assign in_frame = in_frame_reg;
  assign hsync    = hsync_reg;
  assign vsync    = vsync_reg;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing. Two instances share one clock:
//   dut_a: default 800x600 timing, checked against a vector table and a
//          measured hsync width/period.
//   dut_b: a tiny raster (19 x 11, active-low hsync) so whole frames,
//          vsync, mid-frame reset and random reset storms fit in the run.
// A reference process per instance predicts every cycle's outputs from
// the number of pixels elapsed since reset (plain div/mod arithmetic).
module tb_vga_timing;

  // Small raster for dut_b.
  localparam int BHV = 10, BHF = 2, BHS = 3, BHB = 4;  // 19 clocks/line
  localparam int BVV = 6,  BVF = 1, BVS = 2, BVB = 2;  // 11 lines/frame
  localparam bit BHP = 1'b0, BVP = 1'b1;
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;

  bit   clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic [9:0] xa, ya, xb, yb;
  logic       ina, hsa, vsa, inb, hsb, vsb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vga_timing dut_a (
    .clk(clk), .reset(rst_a), .x(xa), .y(ya),
    .in_frame(ina), .hsync(hsa), .vsync(vsa)
  );

  vga_timing #(
    .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
    .H_POL(BHP), .V_POL(BVP)
  ) dut_b (
    .clk(clk), .reset(rst_b), .x(xb), .y(yb),
    .in_frame(inb), .hsync(hsb), .vsync(vsb)
  );

  // Packed observation: {x, y, in_frame, hsync, vsync}
  function automatic logic [22:0] pack(int px, int py, bit inf, bit hs, bit vs);
    logic [9:0] xv, yv;
    xv = 10'(px);
    yv = 10'(py);
    return {xv, yv, inf, hs, vs};
  endfunction

  // Expected outputs for the n-th pixel after reset release.
  function automatic logic [22:0] ref_pix(int n, int hv, int hf, int hs, int hb,
                                          int vv, int vf, int vs, int vb,
                                          bit hp, bit vp);
    int ht, vt, p, h, v;
    bit inf, hact, vact;
    ht   = hv + hf + hs + hb;
    vt   = vv + vf + vs + vb;
    p    = n % (ht * vt);
    h    = p % ht;
    v    = p / ht;
    inf  = (h < hv) && (v < vv);
    hact = (h >= hv + hf) && (h < hv + hf + hs);
    vact = (v >= vv + vf) && (v < vv + vf + vs);
    return pack(inf ? h : 0, inf ? v : 0, inf, hact ? hp : !hp, vact ? vp : !vp);
  endfunction

  task automatic chk(string nm, logic [22:0] act, logic [22:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got x=%0d y=%0d in_frame=%b hsync=%b vsync=%b, want x=%0d y=%0d in_frame=%b hsync=%b vsync=%b",
               nm, act[22:13], act[12:3], act[2], act[1], act[0],
               exp[22:13], exp[12:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Per-cycle reference checking; resets are driven on negedges so the
  // value seen here at posedge is the one the DUT samples.
  initial begin
    int n;
    logic [22:0] e;
    n = 0;
    forever begin
      @(posedge clk);
      if (rst_a) begin
        e = pack(0, 0, 1'b0, 1'b0, 1'b0);
        n = 0;
      end else begin
        e = ref_pix(n, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
        n++;
      end
      #1;
      chk("model_a", {xa, ya, ina, hsa, vsa}, e);
    end
  end

  initial begin
    int n;
    logic [22:0] e;
    n = 0;
    forever begin
      @(posedge clk);
      if (rst_b) begin
        e = pack(0, 0, 1'b0, !BHP, !BVP);
        n = 0;
      end else begin
        e = ref_pix(n, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, BHP, BVP);
        n++;
      end
      #1;
      chk("model_b", {xb, yb, inb, hsb, vsb}, e);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int k;       // edge number after reset release (1 = first edge)
    int ex;
    int ey;
    bit einf;
    bit ehs;
    bit evs;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int cur, rise_k, last_rise, nrise, ymax, last_fs, nfs;
    bit prev;

    // Hand-derived vectors for the default timing: output at edge k
    // shows pixel k-1 of the raster.
    tbl[0]  = '{1,    0,   0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2,    1,   0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{800,  799, 0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{801,  0,   0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{840,  0,   0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{841,  0,   0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{968,  0,   0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{969,  0,   0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1056, 0,   0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1057, 0,   1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1857, 0,   0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2113, 0,   2, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{2200, 87,  2, 1'b1, 1'b0, 1'b0};

    // Reset held for 4 clocks: both instances at reset values.
    repeat (4) @(negedge clk);
    chk("reset_a", {xa, ya, ina, hsa, vsa}, pack(0, 0, 1'b0, 1'b0, 1'b0));
    chk("reset_b", {xb, yb, inb, hsb, vsb}, pack(0, 0, 1'b0, !BHP, !BVP));
    rst_a = 1'b0;
    cur = 0;

    for (int i = 0; i < 13; i++) begin
      repeat (tbl[i].k - cur) @(posedge clk);
      cur = tbl[i].k;
      #2;
      chk($sformatf("vec_a_k%0d", tbl[i].k), {xa, ya, ina, hsa, vsa},
          pack(tbl[i].ex, tbl[i].ey, tbl[i].einf, tbl[i].ehs, tbl[i].evs));
    end

    // hsync width, position and period over two lines.
    prev = hsa;
    nrise = 0;
    rise_k = 0;
    last_rise = 0;
    for (int i = 0; i < 2400; i++) begin
      @(posedge clk);
      cur++;
      #2;
      if (hsa && !prev) begin
        chk_int("hsync_rise_pos", (cur - 1) % 1056, 840);
        if (nrise > 0) chk_int("hsync_period", cur - last_rise, 1056);
        last_rise = cur;
        rise_k = cur;
        nrise++;
      end
      if (!hsa && prev && nrise > 0) chk_int("hsync_width", cur - rise_k, 128);
      prev = hsa;
    end
    chk_int("hsync_rises_seen", (nrise >= 2) ? 1 : 0, 1);

    // Small raster: vsync timing, frame period, y range.
    @(negedge clk);
    rst_b = 1'b0;
    cur = 0;
    prev = vsb;
    nrise = 0;
    rise_k = 0;
    ymax = 0;
    nfs = 0;
    last_fs = 0;
    for (int i = 0; i < 3 * BHT * BVT + 10; i++) begin
      @(posedge clk);
      cur++;
      #2;
      if (int'(yb) > ymax) ymax = int'(yb);
      if (vsb && !prev) begin
        chk_int("vsync_rise_pos", (cur - 1) % (BHT * BVT), (BVV + BVF) * BHT);
        rise_k = cur;
        nrise++;
      end
      if (!vsb && prev && nrise > 0) chk_int("vsync_width", cur - rise_k, BVS * BHT);
      if (inb && xb == 10'd0 && yb == 10'd0) begin
        if (nfs > 0) chk_int("frame_period", cur - last_fs, BHT * BVT);
        last_fs = cur;
        nfs++;
      end
      prev = vsb;
    end
    chk_int("y_max", ymax, BVV - 1);
    chk_int("frames_seen", (nfs >= 3) ? 1 : 0, 1);

    // Reset in the middle of line 3, then restart from pixel (0,0).
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (3 * BHT + 5) @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #2;
    chk("midframe_reset", {xb, yb, inb, hsb, vsb}, pack(0, 0, 1'b0, !BHP, !BVP));
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #2;
    chk("restart_pixel0", {xb, yb, inb, hsb, vsb}, pack(0, 0, 1'b1, !BHP, !BVP));

    // Random run lengths and reset pulses; the reference process checks
    // every cycle.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(1, 500)) @(negedge clk);
      rst_b = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_b = 1'b0;
    end
    repeat (50) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
